spi_slave: RTL and testbench
============================

# spi_slave

SPI responder (mode 0: clock idle low, MSB first, 8-bit bytes) for the far end of the team's SPI master link. Oversamples `spi_clk`, `spi_mosi` and `spi_cs_n` in the `clk` domain and deserialises MOSI into `rx_data`. Serialises a byte from a one-entry transmit holding register onto `spi_miso`. Used wherever a block must act as the SPI peripheral while the controller toggles `spi_clk` at `limit` system clocks per half period.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `spi_clk`, `spi_mosi`, `spi_cs_n`; legal values ≥ 2.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `spi_clk` in 1: SPI clock from the master; asynchronous to `clk`.
- `spi_mosi` in 1: serial data from the master.
- `spi_cs_n` in 1: chip select, active-low.
- `spi_miso` out 1: serial data to the master; registered.
- `tx_data` in 8: next byte to send.
- `tx_load` in 1: one-cycle strobe; writes `tx_data` into the holding register.
- `tx_pending` out 1: holding register full, not yet consumed.
- `tx_underrun` out 1: one-cycle pulse; a byte started with the holding register empty.
- `rx_data` out 8: last complete received byte; held until the next byte completes.
- `rx_valid` out 1: one-cycle pulse; `rx_data` updated this cycle.
- `busy` out 1: synchronised chip select active (state ACTIVE).

## Operation
- **Reset values:** `spi_miso`=0, `rx_data`=0x00, `rx_valid`=0, `tx_pending`=0, `tx_underrun`=0, `busy`=0. Shift registers, bit counter and holding register clear to 0. State is IDLE.
- **Synchronisation:** each SPI input passes through `SYNC_STAGES` flops; one extra flop on synced `spi_clk` gives the previous value.
  - rise = `sclk_s & ~sclk_prev`; fall = `~sclk_s & sclk_prev`.
  - Synced `spi_mosi` uses the same depth, so it stays aligned with synced `spi_clk`.
- **State machine:**
  - IDLE → ACTIVE when synced CS goes low. This is a **load event**.
  - ACTIVE → IDLE when synced CS goes high, from any bit position.
  - SPI clock edges are ignored in IDLE.
- **Load event** (CS entry, or a fall with bit counter = 0 in ACTIVE):
  - If `tx_pending`=1: tx shift ← holding register; `tx_pending` ← 0.
  - If `tx_pending`=0: tx shift ← 0x00; `tx_underrun` pulses.
  - In both cases `spi_miso` ← new tx shift bit 7, and the bit counter is 0.
- **Rise (ACTIVE):**
  - rx shift ← {rx shift[6:0], synced MOSI}; bit counter +1, 3-bit wrapping.
  - When the counter wraps 7→0: `rx_data` ← new rx shift value and `rx_valid`=1 in the same cycle.
- **Fall (ACTIVE, bit counter ≠ 0):** tx shift ← {tx shift[6:0], 0}; `spi_miso` ← new bit 7.
- **Fall (ACTIVE, bit counter = 0):** load event for the next byte; CS stays low for multi-byte frames.
- **`tx_load`:**
  - Holding ← `tx_data`, `tx_pending` ← 1.
  - If `tx_pending`=1 already: overwrite; the previous byte is lost.
  - If `tx_load` coincides with a load event: bypass. Tx shift and `spi_miso` take `tx_data` directly; `tx_pending` stays 0; no underrun.
- **CS deassert mid-byte:** partial rx byte discarded (no `rx_valid`); bit counter ← 0; `spi_miso` ← 0; holding register and `tx_pending` untouched.
- **Fall after the final byte:** consumes a pending byte or pulses `tx_underrun`. Bits loaded this way are never clocked out if CS then rises.
- **IDLE:** `spi_miso` held 0.
- **`rst` mid-frame:** all state returns to reset values immediately. A frame already in progress is not resumed; activity restarts only at the next CS high→low.

## Timing
- **Input latency:** an SPI pin edge is acted on `SYNC_STAGES`+1 `clk` cycles after it is captured (3 at default).
- **`rx_valid`:** asserts `SYNC_STAGES`+1 cycles after the 8th `spi_clk` rise of a byte; 1 cycle wide.
- **`spi_miso` update:** changes `SYNC_STAGES`+1 cycles after a `spi_clk` fall, or after the CS fall.
- **Master constraint:** `limit` ≥ `SYNC_STAGES`+2, so `spi_miso` settles before the master's sampling rise.
- **CS setup:** CS must go low ≥ `SYNC_STAGES`+2 `clk` cycles before the first `spi_clk` rise.
- **Holding register:** `tx_load` → `tx_pending`=1 on the next cycle.
- **Throughput:** one byte per 16·`limit` `clk` cycles, with no gaps required between bytes.

## Test plan
- **Single byte:** `limit`=4; `tx_load` 0xA5; CS low; master sends 0x3C → exactly one `rx_valid` with `rx_data`=0x3C; master receives 0xA5; `tx_pending` returns to 0; `tx_underrun` never asserts.
- **Two-byte frame:** CS held low; 0x11 preloaded; 0x22 loaded after the first `rx_valid`; master sends 0x81 then 0x7E → `rx_data` 0x81 then 0x7E, two `rx_valid` pulses; master receives 0x11 then 0x22.
- **Underrun:** no `tx_load`; master sends 0xFF → master receives 0x00; one `tx_underrun` pulse at CS entry; `rx_data`=0xFF.
- **Abort:** CS rises after 3 bits of 0xF0 → no `rx_valid`; `spi_miso`=0, `busy`=0. A new frame sending 0x5A → `rx_data`=0x5A.
- **Bypass:** `tx_load` 0xC3 in the exact cycle the CS-entry load event occurs (empty holding register) → master receives 0xC3; `tx_pending` stays 0; no underrun.
- **Reset mid-frame:** assert `rst` after 4 bits → every output at its reset value while `rst` is high. A following fresh frame with preloaded 0x99, master sending 0x66 → master receives 0x99, `rx_data`=0x66.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples the SPI pins in the clk domain, deserialises
// MOSI into rx_data and serialises a byte from a one-entry holding register onto MISO.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_pending,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchroniser chains and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   sclk_fall;

  // Architectural state
  state_t                 state;
  state_t                 state_d;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       bit_cnt_d;
  // Only seven received bits need holding; the eighth arrives with the completing edge.
  logic [BYTE_W-2:0]      rx_shift;
  logic [BYTE_W-2:0]      rx_shift_d;
  // Bits still to be sent after the one currently on spi_miso.
  logic [BYTE_W-2:0]      tx_shift;
  logic [BYTE_W-2:0]      tx_shift_d;
  logic [BYTE_W-1:0]      hold;
  logic [BYTE_W-1:0]      hold_d;
  logic                   cs_armed;
  logic                   cs_armed_d;

  // Next values of the registered outputs
  logic                   miso_d;
  logic                   pending_d;
  logic                   underrun_d;
  logic [BYTE_W-1:0]      rx_data_d;
  logic                   rx_valid_d;
  logic                   busy_d;

  // Load-event helpers
  logic                   load_evt;
  logic [BYTE_W-1:0]      load_byte;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // Bring the asynchronous SPI pins into the clk domain; all chains share one depth
  // so MOSI stays aligned with the clock edge it belongs to. The CS chain clears to
  // "asserted" and is qualified by cs_armed, so a CS already low when reset drops
  // does not start a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_s;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      cs_armed    <= 1'b0;
      spi_miso    <= 1'b0;
      tx_pending  <= 1'b0;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      rx_shift    <= rx_shift_d;
      tx_shift    <= tx_shift_d;
      hold        <= hold_d;
      cs_armed    <= cs_armed_d;
      spi_miso    <= miso_d;
      tx_pending  <= pending_d;
      tx_underrun <= underrun_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      busy        <= busy_d;
    end
  end

  // Next-state, shifting and holding-register logic
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    rx_shift_d = rx_shift;
    tx_shift_d = tx_shift;
    hold_d     = hold;
    cs_armed_d = cs_armed | cs_s;
    miso_d     = spi_miso;
    pending_d  = tx_pending;
    underrun_d = 1'b0;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    load_evt   = 1'b0;
    load_byte  = '0;

    case (state)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_armed && !cs_s) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load_evt  = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          // Deselect: drop any partial byte, leave the holding register alone.
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          miso_d     = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift[BYTE_W-3:0], mosi_s};
          bit_cnt_d  = bit_cnt + CNT_W'(1);
          if (&bit_cnt) begin
            rx_data_d  = {rx_shift, mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt == '0) begin
            load_evt = 1'b1;
          end else begin
            {miso_d, tx_shift_d} = {tx_shift, 1'b0};
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A strobe coinciding with a load event bypasses the holding register.
    if (load_evt) begin
      if (tx_load) begin
        load_byte = tx_data;
      end else if (tx_pending) begin
        load_byte = hold;
        pending_d = 1'b0;
      end else begin
        load_byte  = '0;
        underrun_d = 1'b1;
      end
      {miso_d, tx_shift_d} = load_byte;
    end else if (tx_load) begin
      hold_d    = tx_data;
      pending_d = 1'b1;
    end

    busy_d = (state_d == ACTIVE);
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bus-functional SPI master plus a transaction-level model
// of the holding register, with a per-cycle monitor on the DUT outputs.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_pending;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_miso   (spi_miso),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_pending (tx_pending),
    .tx_underrun(tx_underrun),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one-entry holding register and expected-event bookkeeping.
  bit         pend_v = 1'b0;
  logic [7:0] pend_b = 8'h00;
  int         exp_und = 0;
  int         und_cnt = 0;
  logic [7:0] exp_rx [$];
  logic [7:0] last_rx = 8'h00;
  bit         chk_busy = 1'b0;
  int         limit = 4;
  logic       cs_hist [3] = '{1'b1, 1'b1, 1'b1};

  logic [7:0] fr_mo   [4];
  logic [7:0] fr_ld   [4];
  logic [7:0] fr_got  [4];
  int         fr_ldat [4];
  int         fr_n;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Byte the slave must present at a load event.
  function automatic logic [7:0] model_load(input bit bypass, input logic [7:0] b);
    if (bypass) return b;
    if (pend_v) begin
      pend_v = 1'b0;
      return pend_b;
    end
    exp_und++;
    return 8'h00;
  endfunction

  function automatic void model_tx_load(input logic [7:0] b);
    pend_v = 1'b1;
    pend_b = b;
  endfunction

  // Per-cycle monitor: busy follows CS three cycles late, MISO idles low,
  // rx_data only moves with rx_valid and carries the bytes in send order.
  always @(posedge clk) begin
    #1;
    cs_hist[2] = cs_hist[1];
    cs_hist[1] = cs_hist[0];
    cs_hist[0] = spi_cs_n;
    if (rst) begin
      last_rx = 8'h00;
    end else begin
      if (chk_busy) chk1("busy", busy, !cs_hist[2]);
      if (!busy) chk1("miso_idle", spi_miso, 1'b0);
      if (tx_underrun) und_cnt++;
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid_unexpected: got rx_data %02h expected no pulse at %0t", rx_data, $time);
        end else begin
          chk8("rx_byte", rx_data, exp_rx.pop_front());
        end
        last_rx = rx_data;
      end else begin
        chk8("rx_hold", rx_data, last_rx);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    model_tx_load(b);
    chk1("preload_pending", tx_pending, 1'b1);
    cyc(1);
  endtask

  // Master: shifts nbits MSB first, samples MISO just before each rise.
  task automatic send_bits(input logic [7:0] mo, input int nbits, input int load_at,
                           input logic [7:0] ld, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      cyc(limit);
      mi[i] = spi_miso;
      spi_clk = 1'b1;
      if (i == load_at) begin
        cyc(limit - 1);
        tx_data = ld;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        model_tx_load(ld);
        chk1("midbyte_pending", tx_pending, 1'b1);
      end else begin
        cyc(limit);
      end
      spi_clk = 1'b0;
    end
  endtask

  // Full frame of fr_n bytes from the fr_* tables.
  task automatic run_frame(input bit bypass, input logic [7:0] byp);
    logic [7:0] exp_tx;
    logic [7:0] got;
    int         und0;
    spi_cs_n = 1'b0;
    if (bypass) begin
      cyc(2);
      tx_data = byp;
      tx_load = 1'b1;
      und0 = und_cnt;
      cyc(1);
      tx_load = 1'b0;
      exp_tx = model_load(1'b1, byp);
      chk1("bypass_pending", tx_pending, pend_v);
      chki("bypass_no_underrun", und_cnt, und0);
      cyc(3);
    end else begin
      cyc(6);
      exp_tx = model_load(1'b0, 8'h00);
    end
    for (int k = 0; k < fr_n; k++) begin
      exp_rx.push_back(fr_mo[k]);
      send_bits(fr_mo[k], 8, fr_ldat[k], fr_ld[k], got);
      chk8("miso_byte", got, exp_tx);
      fr_got[k] = got;
      exp_tx = model_load(1'b0, 8'h00);
    end
    cyc(limit);
    spi_cs_n = 1'b1;
    cyc(6);
    chki("underrun_count", und_cnt, exp_und);
    chk1("pending_after_frame", tx_pending, pend_v);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] tmp;
    int         u0;
    bit         byp;

    rst = 1'b1;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    tx_data = 8'h00;
    tx_load = 1'b0;
    cyc(3);
    chk1("rst_miso", spi_miso, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_pending", tx_pending, 1'b0);
    chk1("rst_underrun", tx_underrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    cyc(4);
    chk_busy = 1'b1;

    // Single byte; a filler loaded after rx_valid absorbs the trailing load event.
    limit = 4;
    u0 = und_cnt;
    preload(8'hA5);
    fr_n = 1;
    fr_mo[0] = 8'h3C; fr_ldat[0] = 0; fr_ld[0] = 8'h77;
    run_frame(1'b0, 8'h00);
    chk8("single_miso", fr_got[0], 8'hA5);
    chk8("single_rx", rx_data, 8'h3C);
    chki("single_underrun", und_cnt - u0, 0);
    chk1("single_pending", tx_pending, 1'b0);

    // Two-byte frame; second tx byte loaded after the first rx_valid.
    u0 = und_cnt;
    preload(8'h11);
    fr_n = 2;
    fr_mo[0] = 8'h81; fr_ldat[0] = 0;  fr_ld[0] = 8'h22;
    fr_mo[1] = 8'h7E; fr_ldat[1] = -1; fr_ld[1] = 8'h00;
    run_frame(1'b0, 8'h00);
    chk8("two_miso0", fr_got[0], 8'h11);
    chk8("two_miso1", fr_got[1], 8'h22);
    chk8("two_rx", rx_data, 8'h7E);
    chki("two_underrun", und_cnt - u0, 1);

    // Underrun: nothing loaded, so entry and trailing fall both underrun.
    u0 = und_cnt;
    fr_n = 1;
    fr_mo[0] = 8'hFF; fr_ldat[0] = -1;
    run_frame(1'b0, 8'h00);
    chk8("under_miso", fr_got[0], 8'h00);
    chk8("under_rx", rx_data, 8'hFF);
    chki("under_count", und_cnt - u0, 2);

    // Abort after three bits, then a clean frame.
    spi_cs_n = 1'b0;
    cyc(6);
    tmp = model_load(1'b0, 8'h00);
    send_bits(8'hF0, 3, -1, 8'h00, got);
    chk8("abort_miso_bits", got, tmp);
    cyc(2);
    spi_cs_n = 1'b1;
    cyc(6);
    chk1("abort_miso", spi_miso, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk8("abort_rx_kept", rx_data, 8'hFF);
    fr_n = 1;
    fr_mo[0] = 8'h5A; fr_ldat[0] = -1;
    run_frame(1'b0, 8'h00);
    chk8("after_abort_rx", rx_data, 8'h5A);

    // Bypass at CS entry with an empty holding register.
    u0 = und_cnt;
    fr_n = 1;
    fr_mo[0] = 8'h42; fr_ldat[0] = 0; fr_ld[0] = 8'h55;
    run_frame(1'b1, 8'hC3);
    chk8("bypass_miso", fr_got[0], 8'hC3);
    chki("bypass_underrun", und_cnt - u0, 0);

    // Reset mid-frame with CS held low: nothing may restart until CS toggles.
    spi_cs_n = 1'b0;
    cyc(6);
    tmp = model_load(1'b0, 8'h00);
    send_bits(8'hAB, 4, -1, 8'h00, got);
    chk_busy = 1'b0;
    rst = 1'b1;
    pend_v = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_miso", spi_miso, 1'b0);
    chk8("midrst_rx", rx_data, 8'h00);
    cyc(3);
    chk1("midrst_pending", tx_pending, 1'b0);
    chk1("midrst_underrun", tx_underrun, 1'b0);
    chk1("midrst_rx_valid", rx_valid, 1'b0);
    rst = 1'b0;
    cyc(8);
    chk1("no_restart_busy", busy, 1'b0);
    spi_cs_n = 1'b1;
    cyc(6);
    chk_busy = 1'b1;
    preload(8'h99);
    fr_n = 1;
    fr_mo[0] = 8'h66; fr_ldat[0] = -1;
    run_frame(1'b0, 8'h00);
    chk8("after_rst_miso", fr_got[0], 8'h99);
    chk8("after_rst_rx", rx_data, 8'h66);

    // Randomised frames.
    for (int f = 0; f < 25; f++) begin
      limit = int'($urandom_range(4, 7));
      if ($urandom_range(0, 1) == 1) preload(8'($urandom));
      if ($urandom_range(0, 3) == 0) preload(8'($urandom));
      fr_n = int'($urandom_range(1, 3));
      for (int k = 0; k < fr_n; k++) begin
        fr_mo[k]   = 8'($urandom);
        fr_ld[k]   = 8'($urandom);
        fr_ldat[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      end
      byp = !pend_v && ($urandom_range(0, 4) == 0);
      run_frame(byp, 8'($urandom));
    end

    cyc(4);
    chki("rx_queue_empty", exp_rx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
